// File: rtl/axi_profile_win_ctrl.sv
// Purpose: measurement-window sequencer; counts per-channel AXI handshakes over N-cycle windows.
// Latency: snapshots and SNAP_VALID appear the cycle after the last window cycle.
// Backpressure: none; observes handshakes only, never stalls the bus.
module axi_profile_win_ctrl #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 32
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             CFG_EN,
  input  logic             CFG_CLR,
  input  logic             CFG_CONT,
  input  logic [WIN_W-1:0] CFG_WIN_LEN,
  input  logic             AW_HS,
  input  logic             W_HS,
  input  logic             B_HS,
  input  logic             AR_HS,
  input  logic             R_HS,
  output logic [CNT_W-1:0] SNAP_AW,
  output logic [CNT_W-1:0] SNAP_W,
  output logic [CNT_W-1:0] SNAP_B,
  output logic [CNT_W-1:0] SNAP_AR,
  output logic [CNT_W-1:0] SNAP_R,
  output logic             SNAP_VALID,
  output logic [15:0]      WIN_NUM,
  output logic             WIN_ACTIVE,
  output logic             OVF
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic [WIN_W-1:0]        timer;
  logic [4:0][CNT_W-1:0]   live;
  logic [4:0][CNT_W-1:0]   live_nxt;
  logic [4:0][CNT_W-1:0]   snap;
  logic [4:0]              hs;
  logic                    sat_hit;
  logic                    len_nz;

  // Channel order in all packed arrays: AW, W, B, AR, R (bit 0 .. bit 4).
  assign hs     = {R_HS, AR_HS, B_HS, W_HS, AW_HS};
  assign len_nz = |CFG_WIN_LEN;

  assign SNAP_AW = snap[0];
  assign SNAP_W  = snap[1];
  assign SNAP_B  = snap[2];
  assign SNAP_AR = snap[3];
  assign SNAP_R  = snap[4];

  // Saturating increment of every live counter; flags an increment lost to saturation.
  always_comb begin
    live_nxt = live;
    sat_hit  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (hs[i]) begin
        if (&live[i]) sat_hit = 1'b1;
        else          live_nxt[i] = live[i] + CNT_W'(1);
      end
    end
  end

  // Window FSM with counters, snapshots and status outputs all registered here.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      timer      <= '0;
      live       <= '0;
      snap       <= '0;
      SNAP_VALID <= 1'b0;
      WIN_NUM    <= '0;
      WIN_ACTIVE <= 1'b0;
      OVF        <= 1'b0;
    end else if (CFG_CLR) begin
      // Clear dominates every state and holds the block in IDLE.
      state      <= IDLE;
      timer      <= '0;
      live       <= '0;
      snap       <= '0;
      SNAP_VALID <= 1'b0;
      WIN_NUM    <= '0;
      WIN_ACTIVE <= 1'b0;
      OVF        <= 1'b0;
    end else begin
      SNAP_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (CFG_EN && len_nz) begin
            state      <= RUN;
            timer      <= CFG_WIN_LEN - WIN_W'(1);
            live       <= '0;
            WIN_ACTIVE <= 1'b1;
          end
        end
        RUN: begin
          if (!CFG_EN) begin
            // Abort: discard the partial window, keep the last snapshot.
            state      <= IDLE;
            live       <= '0;
            WIN_ACTIVE <= 1'b0;
          end else begin
            if (sat_hit) OVF <= 1'b1;
            if (timer != '0) begin
              timer <= timer - WIN_W'(1);
              live  <= live_nxt;
            end else begin
              // Last window cycle: this cycle's events go into the snapshot,
              // so the next window starts from zero without losing any.
              snap       <= live_nxt;
              SNAP_VALID <= 1'b1;
              WIN_NUM    <= WIN_NUM + 16'd1;
              live       <= '0;
              if (CFG_CONT && len_nz) begin
                timer <= CFG_WIN_LEN - WIN_W'(1);
              end else if (CFG_CONT) begin
                state      <= IDLE;
                WIN_ACTIVE <= 1'b0;
              end else begin
                state      <= DONE;
                WIN_ACTIVE <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (!CFG_EN) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          WIN_ACTIVE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_profile_win_ctrl.sv
// Purpose: directed, table-driven check of the profiler window sequencer.
// Latency: outputs sampled 1 time unit after each rising ACLK edge.
// Backpressure: not applicable; inputs are driven every cycle.
module tb_axi_profile_win_ctrl;

  localparam logic [4:0] H_AW = 5'b00001;
  localparam logic [4:0] H_W  = 5'b00010;
  localparam logic [4:0] H_B  = 5'b00100;
  localparam logic [4:0] H_AR = 5'b01000;
  localparam logic [4:0] H_R  = 5'b10000;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        en = 1'b0, clr = 1'b0, cont = 1'b0;
  logic [31:0] win_len = '0;
  logic [4:0]  hs = '0;

  logic [31:0] s_aw, s_w, s_b, s_ar, s_r;
  logic        sv, act, ovf;
  logic [15:0] wn;

  logic [3:0]  t_aw, t_w, t_b, t_ar, t_r;
  logic        t_sv, t_act, t_ovf;
  logic [15:0] t_wn;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_profile_win_ctrl #(.CNT_W(32), .WIN_W(32)) u_dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .CFG_EN(en), .CFG_CLR(clr), .CFG_CONT(cont),
    .CFG_WIN_LEN(win_len), .AW_HS(hs[0]), .W_HS(hs[1]), .B_HS(hs[2]), .AR_HS(hs[3]),
    .R_HS(hs[4]), .SNAP_AW(s_aw), .SNAP_W(s_w), .SNAP_B(s_b), .SNAP_AR(s_ar),
    .SNAP_R(s_r), .SNAP_VALID(sv), .WIN_NUM(wn), .WIN_ACTIVE(act), .OVF(ovf)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation checks.
  axi_profile_win_ctrl #(.CNT_W(4), .WIN_W(32)) u_sat (
    .ACLK(ACLK), .ARESETn(ARESETn), .CFG_EN(en), .CFG_CLR(clr), .CFG_CONT(cont),
    .CFG_WIN_LEN(win_len), .AW_HS(hs[0]), .W_HS(hs[1]), .B_HS(hs[2]), .AR_HS(hs[3]),
    .R_HS(hs[4]), .SNAP_AW(t_aw), .SNAP_W(t_w), .SNAP_B(t_b), .SNAP_AR(t_ar),
    .SNAP_R(t_r), .SNAP_VALID(t_sv), .WIN_NUM(t_wn), .WIN_ACTIVE(t_act), .OVF(t_ovf)
  );

  typedef struct {
    logic        en, clr, cont;
    logic [31:0] len;
    logic [4:0]  hs;
    logic        act, sv, ovf;
    logic [15:0] wn;
    logic [31:0] e_aw, e_w, e_b, e_ar, e_r;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic e, c, ct, input logic [31:0] l, input logic [4:0] h,
                             input logic a, s, input logic [15:0] n,
                             input logic [31:0] aw, w, b, ar, r);
    vec_t x;
    x.en = e; x.clr = c; x.cont = ct; x.len = l; x.hs = h;
    x.act = a; x.sv = s; x.ovf = 1'b0; x.wn = n;
    x.e_aw = aw; x.e_w = w; x.e_b = b; x.e_ar = ar; x.e_r = r;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic e, c, ct, input logic [31:0] l, input logic [4:0] h);
    en = e; clr = c; cont = ct; win_len = l; hs = h;
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    // Row 0: reset state. Single-shot, LEN=4, AW held high.
    tbl.push_back(v(0,0,0,0,0,       0,0,0, 0,0,0,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1,0,0,4,H_AW, 1,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,0,4,H_AW,    0,1,1, 4,0,0,0,0));
    tbl.push_back(v(1,0,0,4,H_AW,    0,0,1, 4,0,0,0,0));
    tbl.push_back(v(0,0,0,4,0,       0,0,1, 4,0,0,0,0));
    // Continuous LEN=3, R pattern 1,0,1,1,1,0.
    tbl.push_back(v(1,0,1,3,0,       1,0,1, 4,0,0,0,0));
    tbl.push_back(v(1,0,1,3,H_R,     1,0,1, 4,0,0,0,0));
    tbl.push_back(v(1,0,1,3,0,       1,0,1, 4,0,0,0,0));
    tbl.push_back(v(1,0,1,3,H_R,     1,1,2, 0,0,0,0,2));
    tbl.push_back(v(1,0,1,3,H_R,     1,0,2, 0,0,0,0,2));
    tbl.push_back(v(1,0,1,3,H_R,     1,0,2, 0,0,0,0,2));
    tbl.push_back(v(1,0,1,3,0,       1,1,3, 0,0,0,0,2));
    tbl.push_back(v(0,0,1,3,0,       0,0,3, 0,0,0,0,2));
    // LEN=5 window with B=5, then abort at timer==0 of the next window.
    tbl.push_back(v(1,0,1,5,H_B,     1,0,3, 0,0,0,0,2));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1,0,1,5,H_B, 1,0,3, 0,0,0,0,2));
    tbl.push_back(v(1,0,1,5,H_B,     1,1,4, 0,0,5,0,0));
    for (int k = 0; k < 4; k++) tbl.push_back(v(1,0,1,5,H_B, 1,0,4, 0,0,5,0,0));
    tbl.push_back(v(0,0,1,5,H_B,     0,0,4, 0,0,5,0,0));
    // Clear mid-RUN; EN with CLR high does not start.
    tbl.push_back(v(1,0,1,5,0,       1,0,4, 0,0,5,0,0));
    tbl.push_back(v(1,0,1,5,H_B,     1,0,4, 0,0,5,0,0));
    tbl.push_back(v(1,1,1,5,H_B,     0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,1,1,5,0,       0,0,0, 0,0,0,0,0));
    tbl.push_back(v(0,0,1,5,0,       0,0,0, 0,0,0,0,0));
    // LEN=0 with EN=1 stays idle.
    tbl.push_back(v(1,0,1,0,0,       0,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,1,0,H_AW,    0,0,0, 0,0,0,0,0));
    // LEN=1 continuous: snapshot every cycle equals that cycle's handshakes.
    tbl.push_back(v(1,0,1,1,0,       1,0,0, 0,0,0,0,0));
    tbl.push_back(v(1,0,1,1,H_AW|H_R,1,1,1, 1,0,0,0,1));
    tbl.push_back(v(1,0,1,1,H_W|H_B, 1,1,2, 0,1,1,0,0));
    tbl.push_back(v(1,0,1,1,0,       1,1,3, 0,0,0,0,0));
    tbl.push_back(v(1,0,1,1,5'h1F,   1,1,4, 1,1,1,1,1));
    tbl.push_back(v(0,0,1,1,0,       0,0,4, 1,1,1,1,1));
    // LEN reads 0 at reload: window completes, then back to IDLE.
    tbl.push_back(v(1,0,1,2,0,       1,0,4, 1,1,1,1,1));
    tbl.push_back(v(1,0,1,2,H_AW,    1,0,4, 1,1,1,1,1));
    tbl.push_back(v(1,0,1,0,H_AW|H_AR,0,1,5, 2,0,0,1,0));
    tbl.push_back(v(1,0,1,0,0,       0,0,5, 2,0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,       0,0,5, 2,0,0,1,0));

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].clr, tbl[i].cont, tbl[i].len, tbl[i].hs);
      chk($sformatf("row%0d act", i), {31'd0, act}, {31'd0, tbl[i].act});
      chk($sformatf("row%0d snap_valid", i), {31'd0, sv}, {31'd0, tbl[i].sv});
      chk($sformatf("row%0d win_num", i), {16'd0, wn}, {16'd0, tbl[i].wn});
      chk($sformatf("row%0d ovf", i), {31'd0, ovf}, {31'd0, tbl[i].ovf});
      chk($sformatf("row%0d snap_aw", i), s_aw, tbl[i].e_aw);
      chk($sformatf("row%0d snap_w", i), s_w, tbl[i].e_w);
      chk($sformatf("row%0d snap_b", i), s_b, tbl[i].e_b);
      chk($sformatf("row%0d snap_ar", i), s_ar, tbl[i].e_ar);
      chk($sformatf("row%0d snap_r", i), s_r, tbl[i].e_r);
    end

    // Saturation: 4-bit counters, LEN=20, W always high.
    step(0,1,0,0,0);
    step(1,0,1,20,H_W);
    for (int k = 1; k <= 15; k++) step(1,0,1,20,H_W);
    chk("sat ovf_before", {31'd0, t_ovf}, 32'd0);
    step(1,0,1,20,H_W);
    chk("sat ovf_set", {31'd0, t_ovf}, 32'd1);
    for (int k = 17; k <= 20; k++) step(1,0,1,20,H_W);
    chk("sat snap_w", {28'd0, t_w}, 32'd15);
    chk("sat snap_valid", {31'd0, t_sv}, 32'd1);
    chk("wide snap_w", s_w, 32'd20);
    chk("wide ovf", {31'd0, ovf}, 32'd0);
    chk("wide win_num", {16'd0, wn}, 32'd1);
    for (int k = 0; k < 3; k++) step(1,0,1,20,H_W);
    chk("sat ovf_sticky", {31'd0, t_ovf}, 32'd1);
    chk("sat act_next_win", {31'd0, t_act}, 32'd1);
    step(1,1,1,20,H_W);
    chk("sat ovf_clr", {31'd0, t_ovf}, 32'd0);
    chk("sat act_clr", {31'd0, t_act}, 32'd0);

    // WIN_NUM wrap over 65536 one-cycle windows.
    step(1,0,1,1,H_AW);
    for (int k = 0; k < 65535; k++) step(1,0,1,1,H_AW);
    chk("wrap win_num_max", {16'd0, wn}, 32'h0000_FFFF);
    step(1,0,1,1,H_AW);
    chk("wrap win_num_zero", {16'd0, wn}, 32'd0);
    chk("wrap snap_valid", {31'd0, sv}, 32'd1);
    chk("wrap snap_aw", s_aw, 32'd1);
    chk("wrap act", {31'd0, act}, 32'd1);

    // Asynchronous reset mid-RUN, checked before the next clock edge.
    step(1,0,1,3,H_AW);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst act", {31'd0, act}, 32'd0);
    chk("arst snap_valid", {31'd0, sv}, 32'd0);
    chk("arst snap_aw", s_aw, 32'd0);
    chk("arst win_num", {16'd0, wn}, 32'd0);
    chk("arst ovf", {31'd0, ovf}, 32'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_profile_win_ctrl.md
# axi_profile_win_ctrl

Measurement-window sequencer for the AXI profiler, in the ACLK domain. It counts per-channel AXI handshakes over a programmable window of exactly N ACLK cycles and latches the totals into snapshot registers at window end. It runs single-shot or continuously and produces no counting gap between windows. Its control inputs come from the profiler register block's already-synchronized enable/clear levels, and its snapshot outputs feed that block's read path.

## Interface
Parameters:
- CNT_W, 32, width of each live and snapshot counter
- WIN_W, 32, width of window length and window timer

Ports:
- ACLK  in  1  clock (already decided)
- ARESETn  in  1  reset, asynchronous, active-low (already decided)
- CFG_EN  in  1  profiling enable level, synchronous to ACLK
- CFG_CLR  in  1  clear level, synchronous to ACLK; highest priority
- CFG_CONT  in  1  1 = continuous windows, 0 = single-shot
- CFG_WIN_LEN  in  WIN_W  window length in cycles; sampled at each window start
- AW_HS, W_HS, B_HS, AR_HS, R_HS  in  1 each  channel handshake (VALID&READY) for the current cycle
- SNAP_AW, SNAP_W, SNAP_B, SNAP_AR, SNAP_R  out  CNT_W each  last completed window totals
- SNAP_VALID  out  1  one-cycle pulse when snapshots update
- WIN_NUM  out  16  completed-window count; wraps 0xFFFF -> 0
- WIN_ACTIVE  out  1  high while state == RUN
- OVF  out  1  sticky: a live counter saturated
- All outputs reset to 0. State resets to IDLE. Live counters and timer reset to 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when CFG_EN=1, CFG_CLR=0 and CFG_WIN_LEN!=0. The transition loads timer = CFG_WIN_LEN-1 and clears the live counters.
- If CFG_WIN_LEN==0, the block stays in IDLE regardless of CFG_EN.
- RUN, every cycle: each live counter adds 1 if its HS input is high. Counting saturates at 2^CNT_W-1. An increment attempted at saturation sets OVF.
- RUN, timer != 0: the timer decrements.
- RUN, timer == 0 (last window cycle):
  - Each SNAP_x is set to its live value plus this cycle's increment, saturated.
  - SNAP_VALID=1 and WIN_NUM is incremented.
  - The live counters clear to 0.
  - If CFG_CONT=1: stay in RUN and reload timer = CFG_WIN_LEN-1. A reload value of 0 is legal and gives 1-cycle windows. If CFG_WIN_LEN reads 0 at reload, go to IDLE.
  - If CFG_CONT=0: go to DONE.
- DONE: counters stay idle and snapshots are held. Go to IDLE when CFG_EN=0.
- CFG_EN=0 in RUN (abort): go to IDLE and clear the live counters. There is no SNAP_VALID, and SNAP_x, WIN_NUM and OVF are kept. If the abort coincides with timer==0, the abort wins and no snapshot is taken.
- CFG_CLR=1 in any state: go to IDLE and clear the live counters, timer, SNAP_x, WIN_NUM and OVF. SNAP_VALID=0. The block stays in IDLE while CFG_CLR=1.
- CFG_CONT is sampled at each timer==0 cycle.

## Timing
- Start: first cycle with CFG_EN=1 at edge t puts the block in RUN from t+1. HS events at edges t+1 .. t+N are counted, where N = CFG_WIN_LEN.
- SNAP_x and SNAP_VALID update on the edge that ends the last window cycle. They are visible in the following cycle, for 1 cycle for SNAP_VALID.
- Continuous mode: window k+1 starts on the cycle immediately after window k's last cycle. Zero events are lost and none are double-counted.
- WIN_ACTIVE is registered state, low in IDLE and DONE.
- OVF is set on the edge after the saturating increment attempt.

## Test plan
- Single-shot: CFG_WIN_LEN=4, CONT=0, AW_HS held high, EN raised. Expect WIN_ACTIVE high 4 cycles, then SNAP_AW=4, others 0, SNAP_VALID one pulse, WIN_NUM=1, state DONE. Dropping EN then returns to IDLE.
- Continuous: WIN_LEN=3, CONT=1, R_HS pattern 1,0,1,1,1,0. Expect two SNAP_VALID pulses 3 cycles apart with SNAP_R=2 then 2, WIN_NUM=2, WIN_ACTIVE never deasserts.
- Saturation: CNT_W=4, WIN_LEN=20, W_HS always high. Expect SNAP_W=15 and OVF=1. OVF stays 1 into the next window and clears only on CFG_CLR.
- Abort: complete one window with SNAP_B=5, then drop EN at timer==0 of the next window. Expect no SNAP_VALID, SNAP_B still 5, WIN_NUM unchanged, state IDLE.
- Clear: assert CFG_CLR mid-RUN with nonzero snapshots. Expect all SNAP_x=0, WIN_NUM=0, OVF=0 and state IDLE next cycle. With CLR high, EN=1 causes no start.
- Boundaries:
  - WIN_LEN=0 with EN=1: the block stays in IDLE.
  - WIN_LEN=1 continuous: SNAP_VALID every cycle, each SNAP_x equal to that cycle's HS value.
  - 65536 one-cycle windows: WIN_NUM wraps to 0.
  - ARESETn asserted mid-RUN: all outputs 0 asynchronously.
